uart_rx: RTL

Serial receive engine of the 16550 UART. Consumes the 16x `sample_tick` produced by `baud_gen`, synchronizes the asynchronous `rxd` line, detects and validates start bits, samples each bit at mid-cell and assembles 5–8 bit characters. It checks parity and the first stop bit and detects break. Each character is delivered as a single-cycle `rx_valid` pulse to the downstream RX FIFO / LSR logic.

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side character bus of the 16550 UART: one delivered character plus
// its status flags, from the receive engine to the RX FIFO / LSR logic.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  parity_err;
    logic                  framing_err;
    logic                  break_int;
    logic                  rx_busy;

    modport master (
        output rx_data, rx_valid, parity_err, framing_err, break_int, rx_busy
    );

    modport slave (
        input rx_data, rx_valid, parity_err, framing_err, break_int, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 16550 serial receive engine: synchronizes rxd, validates the start bit and
// samples each bit at mid-cell using the 16x sample_tick from baud_gen.
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       sample_tick,
    input  logic       active,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    uart_rx_if.master  rx_if
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_MARK
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_cnt;
    logic [1:0]             wls_q;
    logic                   pen_q, eps_q, sp_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   par_q;
    logic                   sample_data, sample_par, sample_stop;
    logic                   counting, last_bit, exp_par;
    logic [DATA_WIDTH-1:0]  rx_data_q;
    logic                   rx_valid_q, parity_err_q, framing_err_q, break_int_q;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign last_bit = (bit_cnt == (3'd4 + {1'b0, wls_q}));
    assign counting = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);
    assign exp_par  = sp_q ? ~eps_q : (eps_q ? ^shift_q : ~^shift_q);

    // Synchronizer resets to mark so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        if (!active) begin
            state_next = IDLE;
        end else if (sample_tick) begin
            case (state)
                IDLE:      if (!rxs) state_next = START;
                START:     if (tick_cnt == 4'd7) state_next = rxs ? IDLE : DATA;
                DATA: begin
                    if (tick_cnt == 4'd15) begin
                        sample_data = 1'b1;
                        if (last_bit) state_next = pen_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (tick_cnt == 4'd15) begin
                        sample_par = 1'b1;
                        state_next = STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt == 4'd15) begin
                        sample_stop = 1'b1;
                        state_next  = rxs ? IDLE : WAIT_MARK;
                    end
                end
                WAIT_MARK: if (rxs) state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Counter clear on state entry is placed last so it overrides the increments
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            wls_q         <= '0;
            pen_q         <= 1'b0;
            eps_q         <= 1'b0;
            sp_q          <= 1'b0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            break_int_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (counting && sample_tick)
                tick_cnt <= tick_cnt + 4'd1;
            if (sample_data) begin
                shift_q[bit_cnt] <= rxs;
                bit_cnt          <= bit_cnt + 3'd1;
            end
            if (sample_par)
                par_q <= rxs;
            if (state_next != state) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end
            if (state == IDLE && state_next == START) begin
                wls_q   <= wls;
                pen_q   <= pen;
                eps_q   <= eps;
                sp_q    <= sp;
                shift_q <= '0;
                par_q   <= 1'b0;
            end
            if (sample_stop) begin
                rx_valid_q    <= 1'b1;
                rx_data_q     <= shift_q;
                parity_err_q  <= pen_q & (par_q != exp_par);
                framing_err_q <= ~rxs;
                break_int_q   <= ~rxs & ~(|shift_q) & ~(pen_q & par_q);
            end
        end
    end

    assign rx_if.rx_data     = rx_data_q;
    assign rx_if.rx_valid    = rx_valid_q;
    assign rx_if.parity_err  = parity_err_q;
    assign rx_if.framing_err = framing_err_q;
    assign rx_if.break_int   = break_int_q;
    assign rx_if.rx_busy     = (state != IDLE);

endmodule
